// File: rtl/axi_mem_pkg.sv
// Shared encodings and the burst legality check for the AXI3 memory slave.
package axi_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    // A burst is refused when its encoding, beat size or wrap length cannot be served.
    function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size,
                                       input logic [3:0] len, input int unsigned nbytes);
        logic bad_wrap;
        bad_wrap = (burst == BURST_WRAP) &&
                   !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
        return (burst == BURST_RSVD) || ((32'd1 << size) > nbytes) || bad_wrap;
    endfunction

endpackage

// File: rtl/axi_mem_slave_beat_addr.sv
// Next-beat address for FIXED / INCR / WRAP bursts; purely combinational.
module axi_beat_addr
    import axi_mem_pkg::*;
#(
    parameter int WIDTH_AD = 32
) (
    input  logic [WIDTH_AD-1:0] addr_i,
    input  logic [2:0]          size_i,
    input  logic [3:0]          len_i,
    input  logic [1:0]          burst_i,
    output logic [WIDTH_AD-1:0] next_o
);

    logic [WIDTH_AD-1:0] nb;
    logic [WIDTH_AD-1:0] span;

    always_comb begin
        nb   = WIDTH_AD'(1) << size_i;
        span = nb * (WIDTH_AD'(len_i) + WIDTH_AD'(1));
        unique case (burst_i)
            BURST_INCR: next_o = (addr_i & ~(nb - WIDTH_AD'(1))) + nb;
            BURST_WRAP: next_o = (addr_i & ~(span - WIDTH_AD'(1))) |
                                 ((addr_i + nb) & (span - WIDTH_AD'(1)));
            default:    next_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI3 slave backed by a 2**ADDR_LENGTH byte memory; one write and one read
// burst in flight at a time, the two directions running independently.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int WIDTH_ID    = 4,
    parameter int WIDTH_AD    = 32,
    parameter int WIDTH_DA    = 32,
    parameter int WIDTH_DS    = WIDTH_DA / 8,
    parameter int ADDR_LENGTH = 12
) (
    input  logic                ARESETn,
    input  logic                ACLK,
    input  logic [WIDTH_ID-1:0] AWID,
    input  logic [WIDTH_AD-1:0] AWADDR,
    input  logic [3:0]          AWLEN,
    input  logic [1:0]          AWLOCK,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [WIDTH_ID-1:0] WID,
    input  logic [WIDTH_DA-1:0] WDATA,
    input  logic [WIDTH_DS-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [WIDTH_ID-1:0] BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [WIDTH_ID-1:0] ARID,
    input  logic [WIDTH_AD-1:0] ARADDR,
    input  logic [3:0]          ARLEN,
    input  logic [1:0]          ARLOCK,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [WIDTH_ID-1:0] RID,
    output logic [WIDTH_DA-1:0] RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);

    localparam int LANE_W = $clog2(WIDTH_DS);
    localparam int WORD_W = ADDR_LENGTH - LANE_W;

    logic [WIDTH_DA-1:0] mem [0:(1<<WORD_W)-1];

    wstate_e             wstate_q, wstate_d;
    logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [WIDTH_ID-1:0] bid_q, bid_d, awid_q, awid_d;
    logic [1:0]          bresp_q, bresp_d, wburst_q, wburst_d;
    logic [WIDTH_AD-1:0] waddr_q, waddr_d, waddr_next;
    logic [3:0]          wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]          wsize_q, wsize_d;
    logic                werr_q, werr_d, wflag_q, wflag_d, wflag_beat, wbeat;

    rstate_e             rstate_q, rstate_d;
    logic                arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [WIDTH_ID-1:0] rid_q, rid_d;
    logic [WIDTH_DA-1:0] rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d, rburst_q, rburst_d;
    logic [WIDTH_AD-1:0] raddr_q, raddr_d, raddr_next;
    logic [3:0]          rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]          rsize_q, rsize_d;
    logic                rerr_q, rerr_d, ar_err;

    logic unused_lock;
    assign unused_lock = ^{AWLOCK, ARLOCK};

    axi_beat_addr #(.WIDTH_AD(WIDTH_AD)) u_wbeat (
        .addr_i(waddr_q), .size_i(wsize_q), .len_i(wlen_q), .burst_i(wburst_q), .next_o(waddr_next)
    );
    axi_beat_addr #(.WIDTH_AD(WIDTH_AD)) u_rbeat (
        .addr_i(raddr_q), .size_i(rsize_q), .len_i(rlen_q), .burst_i(rburst_q), .next_o(raddr_next)
    );

    assign wbeat = (wstate_q == W_DATA) && WVALID && wready_q;

    always_comb begin
        wstate_d  = wstate_q;   awready_d = awready_q;  wready_d = wready_q;
        bvalid_d  = bvalid_q;   bid_d     = bid_q;      bresp_d  = bresp_q;
        awid_d    = awid_q;     waddr_d   = waddr_q;    wlen_d   = wlen_q;
        wsize_d   = wsize_q;    wburst_d  = wburst_q;   wcnt_d   = wcnt_q;
        werr_d    = werr_q;     wflag_d   = wflag_q;
        wflag_beat = wflag_q | (WID != awid_q) | (WLAST != (wcnt_q == wlen_q));
        unique case (wstate_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (AWVALID && awready_q) begin
                    awid_d    = AWID;    waddr_d  = AWADDR;  wlen_d = AWLEN;
                    wsize_d   = AWSIZE;  wburst_d = AWBURST;
                    werr_d    = burst_err(AWBURST, AWSIZE, AWLEN, WIDTH_DS);
                    wcnt_d    = 4'd0;    wflag_d  = 1'b0;
                    awready_d = 1'b0;    wready_d = 1'b1;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (wbeat) begin
                    waddr_d = waddr_next;
                    wcnt_d  = wcnt_q + 4'd1;
                    wflag_d = wflag_beat;
                    // An early WLAST closes the burst as well as the final counted beat.
                    if (wcnt_q == wlen_q || WLAST) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = awid_q;
                        bresp_d  = (werr_q || wflag_beat) ? RESP_SLVERR : RESP_OKAY;
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wstate_q <= W_IDLE;  awready_q <= 1'b0;  wready_q <= 1'b0;  bvalid_q <= 1'b0;
            bid_q    <= '0;      bresp_q   <= '0;    awid_q   <= '0;    waddr_q  <= '0;
            wlen_q   <= '0;      wsize_q   <= '0;    wburst_q <= '0;    wcnt_q   <= '0;
            werr_q   <= 1'b0;    wflag_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;  awready_q <= awready_d;  wready_q <= wready_d;
            bvalid_q <= bvalid_d;  bid_q     <= bid_d;      bresp_q  <= bresp_d;
            awid_q   <= awid_d;    waddr_q   <= waddr_d;    wlen_q   <= wlen_d;
            wsize_q  <= wsize_d;   wburst_q  <= wburst_d;   wcnt_q   <= wcnt_d;
            werr_q   <= werr_d;    wflag_q   <= wflag_d;
        end
    end

    // Memory has no reset; a refused burst leaves it untouched.
    always_ff @(posedge ACLK) begin
        if (wbeat && !werr_q) begin
            for (int i = 0; i < WIDTH_DS; i++) begin
                if (WSTRB[i]) mem[waddr_q[ADDR_LENGTH-1:LANE_W]][i*8 +: 8] <= WDATA[i*8 +: 8];
            end
        end
    end

    always_comb begin
        rstate_d  = rstate_q;   arready_d = arready_q;  rvalid_d = rvalid_q;
        rlast_d   = rlast_q;    rid_d     = rid_q;      rdata_d  = rdata_q;
        rresp_d   = rresp_q;    raddr_d   = raddr_q;    rlen_d   = rlen_q;
        rsize_d   = rsize_q;    rburst_d  = rburst_q;   rcnt_d   = rcnt_q;
        rerr_d    = rerr_q;
        ar_err    = burst_err(ARBURST, ARSIZE, ARLEN, WIDTH_DS);
        unique case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    raddr_d   = ARADDR;  rlen_d   = ARLEN;  rsize_d = ARSIZE;
                    rburst_d  = ARBURST; rerr_d   = ar_err; rcnt_d  = 4'd0;
                    arready_d = 1'b0;    rvalid_d = 1'b1;   rid_d   = ARID;
                    rresp_d   = ar_err ? RESP_SLVERR : RESP_OKAY;
                    rdata_d   = ar_err ? '0 : mem[ARADDR[ADDR_LENGTH-1:LANE_W]];
                    rlast_d   = (ARLEN == 4'd0);
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                // RVALID is always high here, so RREADY alone completes a beat.
                if (RREADY) begin
                    if (rcnt_q == rlen_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        rstate_d  = R_IDLE;
                    end else begin
                        rcnt_d  = rcnt_q + 4'd1;
                        raddr_d = raddr_next;
                        rdata_d = rerr_q ? '0 : mem[raddr_next[ADDR_LENGTH-1:LANE_W]];
                        rlast_d = (rcnt_q + 4'd1 == rlen_q);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rstate_q <= R_IDLE;  arready_q <= 1'b0;  rvalid_q <= 1'b0;  rlast_q  <= 1'b0;
            rid_q    <= '0;      rdata_q   <= '0;    rresp_q  <= '0;    raddr_q  <= '0;
            rlen_q   <= '0;      rsize_q   <= '0;    rburst_q <= '0;    rcnt_q   <= '0;
            rerr_q   <= 1'b0;
        end else begin
            rstate_q <= rstate_d;  arready_q <= arready_d;  rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;   rid_q     <= rid_d;      rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;   raddr_q   <= raddr_d;    rlen_q   <= rlen_d;
            rsize_q  <= rsize_d;   rburst_q  <= rburst_d;   rcnt_q   <= rcnt_d;
            rerr_q   <= rerr_d;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized bench for axi_mem_slave checked against a byte-array memory model.
module tb_axi_mem_slave;

    localparam int WIDTH_ID = 4, WIDTH_AD = 32, WIDTH_DA = 32, WIDTH_DS = 4, ADDR_LENGTH = 12;

    logic                ACLK = 1'b0, ARESETn = 1'b1;
    logic [WIDTH_ID-1:0] AWID, WID, BID, ARID, RID;
    logic [WIDTH_AD-1:0] AWADDR, ARADDR;
    logic [3:0]          AWLEN, ARLEN, WSTRB;
    logic [1:0]          AWLOCK, AWBURST, ARLOCK, ARBURST, BRESP, RRESP;
    logic [2:0]          AWSIZE, ARSIZE;
    logic [WIDTH_DA-1:0] WDATA, RDATA;
    logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic ARVALID, ARREADY, RLAST, RVALID, RREADY;

    axi_mem_slave #(.WIDTH_ID(WIDTH_ID), .WIDTH_AD(WIDTH_AD), .WIDTH_DA(WIDTH_DA),
                    .WIDTH_DS(WIDTH_DS), .ADDR_LENGTH(ADDR_LENGTH)) dut (
        .ARESETn(ARESETn), .ACLK(ACLK),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWLOCK(AWLOCK), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARLOCK(ARLOCK), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic bad_burst(input logic [1:0] b, input int size, input int len);
        if (b == 2'b11) return 1'b1;
        if ((1 << size) > WIDTH_DS) return 1'b1;
        if (b == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
        return 1'b0;
    endfunction

    // Address of beat i, computed directly from the start address.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int size,
                                              input int len, input logic [1:0] b, input int i);
        logic [31:0] nb, span, lower;
        nb    = 32'd1 << size;
        span  = nb * (len + 1);
        lower = start - (start % span);
        case (b)
            2'b01:   return (i == 0) ? start : (start - (start % nb)) + nb * i;
            2'b10:   return lower + ((start - lower + nb * i) % span);
            default: return start;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int base;
        base = int'(a[11:2]) * 4;
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input int size, input logic [1:0] burst, input int wlast_at,
                            input logic wid_bad);
        int n;
        logic err;
        logic [31:0] a;
        err = bad_burst(burst, size, len);
        @(negedge ACLK);
        AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = 3'(size); AWBURST = burst;
        AWLOCK = 2'($urandom); AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("awready", AWREADY, 1);
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int i = 0; i <= wlast_at; i++) begin
            WVALID = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge ACLK);
            WVALID = 1'b1; WID = (wid_bad && i == 0) ? ~id : id;
            WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == wlast_at);
            n = 0;
            while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
            chk("wready", WREADY, 1);
            if (!err) begin
                a = beat_addr(addr, size, len, burst, i);
                for (int l = 0; l < 4; l++)
                    if (ws[i][l]) ref_mem[int'(a[11:2]) * 4 + l] = wd[i][8*l +: 8];
            end
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        chk("wready_end", WREADY, 0);
        BREADY = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge ACLK);
        n = 0;
        while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
        chk("bvalid", BVALID, 1);
        chk("bid", BID, id);
        chk("bresp", BRESP, (err || wlast_at != len || wid_bad) ? 2 : 0);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("bvalid_clr", BVALID, 0);
        chk("awready_back", AWREADY, 1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input logic [1:0] burst, input int stall_beat,
                           input int stall_cycles, input logic rnd_stall);
        int n, beat, stalled;
        logic err;
        logic [31:0] exp;
        err = bad_burst(burst, size, len);
        @(negedge ACLK);
        ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = 3'(size); ARBURST = burst;
        ARLOCK = 2'($urandom); ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("arready", ARREADY, 1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("rvalid_lat", RVALID, 1);
        beat = 0; stalled = 0; n = 0;
        while (beat <= len && n < 300) begin
            exp = err ? 32'd0 : ref_word(beat_addr(addr, size, len, burst, beat));
            chk("rvalid", RVALID, 1);
            chk("rdata", RDATA, exp);
            chk("rlast", RLAST, beat == len);
            chk("rresp", RRESP, err ? 2 : 0);
            chk("rid", RID, id);
            if (beat == stall_beat && stalled < stall_cycles) begin
                RREADY = 1'b0; stalled++;
            end else begin
                RREADY = rnd_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            @(negedge ACLK);
            n++;
            if (RREADY) beat++;
        end
        RREADY = 1'b0;
        chk("rbeats", beat, len + 1);
        chk("rvalid_end", RVALID, 0);
        chk("rlast_end", RLAST, 0);
        chk("arready_back", ARREADY, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0]  id;
        logic [31:0] addr, base;
        logic [1:0]  burst;
        int          len, size;

        AWID = '0; AWADDR = '0; AWLEN = '0; AWLOCK = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARLOCK = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;

        #1 ARESETn = 1'b0;
        #1;
        chk("rst_awready", AWREADY, 0); chk("rst_arready", ARREADY, 0);
        chk("rst_wready", WREADY, 0);   chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);   chk("rst_rlast", RLAST, 0);
        chk("rst_bid", BID, 0);         chk("rst_bresp", BRESP, 0);
        chk("rst_rid", RID, 0);         chk("rst_rresp", RRESP, 0);
        chk("rst_rdata", RDATA, 0);
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("rel_awready", AWREADY, 1); chk("rel_arready", ARREADY, 1);

        // Give every byte a known value.
        for (int b = 0; b < 64; b++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(4'($urandom), 32'(b * 64), 15, 2, 2'b01, 15, 1'b0);
        end

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(4'd1, 32'h0, 0, 2, 2'b01, 0, 1'b0);
        do_read(4'd1, 32'h0, 0, 2, 2'b01, -1, 0, 1'b0);

        wd[0] = 32'h11; ws[0] = 4'b0001; wd[1] = 32'h2200; ws[1] = 4'b0010;
        do_write(4'd2, 32'h0, 1, 0, 2'b01, 1, 1'b0);
        do_read(4'd2, 32'h0, 0, 2, 2'b01, -1, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        do_write(4'd3, 32'h38, 3, 2, 2'b10, 3, 1'b0);
        do_read(4'd3, 32'h30, 3, 2, 2'b01, -1, 0, 1'b0);

        do_read(4'd5, 32'h30, 3, 2, 2'b01, 1, 3, 1'b0);

        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'd4, 32'h80, 3, 2, 2'b01, 2, 1'b0);
        do_read(4'd4, 32'h80, 3, 2, 2'b01, -1, 0, 1'b0);
        do_write(4'd6, 32'h90, 1, 2, 2'b01, 1, 1'b1);
        do_read(4'd7, 32'h40, 2, 2, 2'b11, -1, 0, 1'b0);

        // Reset in the middle of a write burst and a read burst.
        @(negedge ACLK);
        chk("pre_rst_awready", AWREADY, 1); chk("pre_rst_arready", ARREADY, 1);
        AWID = 4'd2; AWADDR = 32'h100; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
        ARID = 4'd3; ARADDR = 32'h200; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; ARVALID = 1'b0;
        WVALID = 1'b1; WID = 4'd2; WDATA = 32'hA5A5_0001; WSTRB = 4'hF; WLAST = 1'b0; RREADY = 1'b1;
        for (int l = 0; l < 4; l++) ref_mem[32'h100 + l] = WDATA[8*l +: 8];
        @(negedge ACLK);
        WDATA = 32'hA5A5_0002;
        #2 ARESETn = 1'b0;
        #1;
        chk("mid_wready", WREADY, 0);   chk("mid_rvalid", RVALID, 0);
        chk("mid_rlast", RLAST, 0);     chk("mid_awready", AWREADY, 0);
        chk("mid_arready", ARREADY, 0); chk("mid_bvalid", BVALID, 0);
        @(negedge ACLK);
        WVALID = 1'b0; RREADY = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        #1 chk("rel_hold_awready", AWREADY, 0);
        @(negedge ACLK);
        chk("rel2_awready", AWREADY, 1); chk("rel2_arready", ARREADY, 1);
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'd9, 32'h300, 3, 2, 2'b01, 3, 1'b0);
        do_read(4'd9, 32'h100, 3, 2, 2'b01, -1, 0, 1'b0);
        do_read(4'd9, 32'h300, 3, 2, 2'b01, -1, 0, 1'b1);

        for (int t = 0; t < 30; t++) begin
            id   = 4'($urandom);
            addr = $urandom;
            size = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
            len  = $urandom_range(0, 15);
            case ($urandom_range(0, 7))
                0, 1, 2: burst = 2'b01;
                3, 4:    burst = 2'b10;
                5:       burst = 2'b00;
                6:       burst = 2'b11;
                default: burst = 2'b01;
            endcase
            if (burst == 2'b10 && $urandom_range(0, 7) != 0) len = (1 << $urandom_range(1, 4)) - 1;
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            if (t % 5 == 0) begin
                base = 32'h800 + ($urandom_range(0, 32'h6FF) & ~32'h3);
                fork
                    do_write(id, base, len, size, burst, len, 1'b0);
                    do_read(~id, $urandom_range(0, 32'h6FF), len, size, burst, -1, 0, 1'b1);
                join
            end else begin
                do_write(id, addr, len, size, burst, len, 1'b0);
                do_read(4'($urandom), addr, len, size, burst, -1, 0, 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- Synthesizable AXI3 slave that answers the bench master: a single write channel engine and a single read channel engine, both backed by an on-chip byte-lane memory of 2**ADDR_LENGTH bytes.
- It is the responder end of the master BFM tasks, so the raw/burst tests run against RTL rather than against another behavioural model.
- One outstanding write and one outstanding read at a time. The two directions run independently and concurrently.

Parameters:
- WIDTH_ID, 4, ID width of AWID/WID/BID/ARID/RID.
- WIDTH_AD, 32, address width. Bits at and above ADDR_LENGTH are ignored, so the memory aliases.
- WIDTH_DA, 32, data width (32/64/128).
- WIDTH_DS, WIDTH_DA/8, strobe width.
- ADDR_LENGTH, 12, log2 of memory size in bytes.

Ports:
- ARESETn  in  1  asynchronous, active-low reset
- ACLK  in  1  clock; all logic on rising edge
- AWID  in  WIDTH_ID  write address ID
- AWADDR  in  WIDTH_AD  write start address
- AWLEN  in  4  write beats minus 1
- AWLOCK  in  2  ignored
- AWSIZE  in  3  bytes per beat = 2**AWSIZE
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WID  in  WIDTH_ID  write data ID
- WDATA  in  WIDTH_DA  write data
- WSTRB  in  WIDTH_DS  write byte strobes
- WLAST  in  1  last write beat
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BID  out  WIDTH_ID  response ID
- BRESP  out  2  write response
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARID, ARADDR, ARLEN, ARLOCK, ARSIZE, ARBURST, ARVALID  in  as AW*  read address channel
- ARREADY  out  1  read address ready
- RID  out  WIDTH_ID  read ID
- RDATA  out  WIDTH_DA  read data
- RRESP  out  2  read response
- RLAST  out  1  last read beat
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0.
  - BID, BRESP, RID, RRESP, RDATA = 0.
  - Both FSMs return to IDLE.
  - Memory contents are not reset.
  - AWREADY and ARREADY go to 1 on the first ACLK edge after release.
- All outputs are registered.
- Burst check at address handshake: ERR is set when burst = 11 or 2**size > WIDTH_DS, or when burst = WRAP and len is not 1, 3, 7 or 15. An ERR burst performs no memory access.
- Beat address (shared function):
  - FIXED: address held.
  - INCR: next = (addr & ~(nb-1)) + nb, where nb = 2**size.
  - WRAP: span = nb*(len+1); next = (addr & ~(span-1)) | ((addr+nb) & (span-1)).
- Write FSM, W_IDLE / W_DATA / W_RESP:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, capture id/addr/len/size/burst, clear beat count and error flag, then AWREADY<=0, WREADY<=1, go W_DATA.
  - W_DATA: each WVALID&WREADY beat writes every byte lane with WSTRB=1 at word (addr >> log2 WIDTH_DS), unless ERR. Address then advances and count increments.
  - W_DATA error flag: set when WID ≠ captured id or when WLAST ≠ (count==len).
  - W_DATA exit: on the beat where count==len or WLAST=1, whichever comes first, WREADY<=0, BVALID<=1, BID<=id, BRESP<=(ERR|flag) ? 10 : 00, go W_RESP.
  - W_RESP: BVALID and BID/BRESP held until BREADY. Then BVALID<=0, AWREADY<=1, go W_IDLE.
- Read FSM, R_IDLE / R_DATA:
  - R_IDLE: ARREADY=1. On handshake, capture fields, ARREADY<=0, RVALID<=1 with beat 0 on the next edge. Latency is 1 cycle from handshake to first RVALID.
  - R_DATA, normal burst: RDATA = full aligned word, and the master selects lanes.
  - R_DATA, ERR burst: RDATA=0 and RRESP=10 on all len+1 beats.
  - RLAST=1 when count==len.
  - Stall: while RVALID&!RREADY, RID/RDATA/RRESP/RLAST are held.
  - Advance: on RVALID&RREADY, the next beat is presented on the next edge (1 beat/cycle).
  - Exit: after the last beat, RVALID<=0, RLAST<=0, ARREADY<=1, go R_IDLE.
- Same-word read and write in the same cycle: the read returns the pre-write data.

Decomposition:
- Package axi_mem_pkg:
  - burst codes FIXED/INCR/WRAP;
  - response codes OKAY=00, SLVERR=10;
  - write FSM state encodings, 2 bits;
  - read FSM state encodings, 1 bit.
- One combinational sub-module, axi_beat_addr (addr, size, len, burst -> next addr), instantiated twice: once for write, once for read.

Test Plan:
- Single write and readback: write id=1, addr 0x0, size=2, len=0, WDATA=0xDEADBEEF, WSTRB=F -> BID=1, BRESP=00. Then read id=1 at 0x0 -> RDATA=0xDEADBEEF, RLAST=1, RRESP=00, RVALID one cycle after AR handshake.
- Narrow INCR write: addr 0x0, size=0, len=1, beat0 WSTRB=0001 WDATA=0x11, beat1 WSTRB=0010 WDATA=0x2200 -> word read at 0x0 has low 16 bits 0x2211, upper bytes unchanged.
- WRAP write: size=2, len=3, start 0x38, data 1,2,3,4 -> written to 0x38, 0x3C, 0x30, 0x34. INCR read from 0x30, len=3 -> 3,4,1,2.
- Read stall: 4-beat read with RREADY=0 for 3 cycles on beat 1 -> RDATA/RLAST stable throughout, 4 beats delivered, RLAST only on beat 3.
- Error paths:
  - WLAST on beat 2 of a len=3 write -> BRESP=10, burst ends.
  - Read with ARBURST=11, len=2 -> 3 beats, RRESP=10, RDATA=0, RLAST on beat 2.
- Reset mid-burst: ARESETn=0 during beat 1 of a 4-beat write and read -> WREADY/RVALID drop asynchronously. After release, AWREADY=ARREADY=1 next edge, and a fresh write completes with OKAY.
